// File: rtl/tdp_ram_pkg.sv
// Shared constants for the true dual-port RAM: read-during-write modes
// and the init FSM state encoding.
package tdp_ram_pkg;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] IDLE = 1'b0;
    localparam logic [STATE_W-1:0] INIT = 1'b1;

endpackage

// File: rtl/tdp_ram_init_ctrl.sv
// Init FSM: after reset, sweeps a write address across every word once,
// holding busy high for exactly DEPTH cycles.
module tdp_ram_init_ctrl
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int INIT_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    logic [STATE_W-1:0] state_reg, state_next;
    logic [ADDR_W-1:0]  cnt_reg, cnt_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == INIT) begin
            cnt_next = cnt_reg + 1'b1;
            // Last word written on this edge; busy drops together with it.
            if (cnt_reg == {ADDR_W{1'b1}}) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= (INIT_ON_RST != 0) ? INIT : IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy      = (state_reg == INIT);
    assign init_we   = busy;
    assign init_addr = cnt_reg;

endmodule

// File: rtl/param_tdp_ram.sv
// Single-clock true dual-port RAM with selectable same-port read-during-write
// behaviour, port-A-wins write arbitration and an optional reset-time clear.
module param_tdp_ram
    import tdp_ram_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 3,
    parameter int                WRITE_MODE  = 0,
    parameter int                INIT_ON_RST = 1,
    parameter logic [DATA_W-1:0] INIT_VAL    = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_valid,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    logic [1:0]        port_en;
    logic [1:0]        port_we;
    logic [1:0]        port_req;
    logic [ADDR_W-1:0] port_addr [2];
    logic [DATA_W-1:0] port_din  [2];

    logic              wr_a_en;
    logic [ADDR_W-1:0] wr_a_addr;
    logic [DATA_W-1:0] wr_a_data;
    logic              wr_b_en;
    logic              collision_reg;

    tdp_ram_init_ctrl #(
        .ADDR_W      (ADDR_W),
        .INIT_ON_RST (INIT_ON_RST)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    assign port_en      = {b_en, a_en};
    assign port_we      = {b_we, a_we};
    assign port_addr[0] = a_addr;
    assign port_addr[1] = b_addr;
    assign port_din[0]  = a_din;
    assign port_din[1]  = b_din;
    assign port_req     = port_en & {2{~busy}};

    // The init sweep borrows port A's write path while busy.
    assign wr_a_en   = busy ? init_we   : (port_req[0] & port_we[0]);
    assign wr_a_addr = busy ? init_addr : port_addr[0];
    assign wr_a_data = busy ? INIT_VAL  : port_din[0];
    assign wr_b_en   = port_req[1] & port_we[1];

    // Port A is written last so it wins a same-address write/write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_b_en) begin
                mem[port_addr[1]] <= port_din[1];
            end
            if (wr_a_en) begin
                mem[wr_a_addr] <= wr_a_data;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] dout_reg;
        logic              valid_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_reg  <= '0;
                valid_reg <= 1'b0;
            end else begin
                valid_reg <= port_req[gi];
                if (port_req[gi]) begin
                    if (port_we[gi] && (WRITE_MODE == WR_FIRST)) begin
                        dout_reg <= port_din[gi];
                    end else begin
                        dout_reg <= mem[port_addr[gi]];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= port_req[0] & port_req[1] & port_we[0] & port_we[1]
                             & (port_addr[0] == port_addr[1]);
        end
    end

    assign a_dout    = g_port[0].dout_reg;
    assign a_valid   = g_port[0].valid_reg;
    assign b_dout    = g_port[1].dout_reg;
    assign b_valid   = g_port[1].valid_reg;
    assign collision = collision_reg;

endmodule

// File: tb/tb_param_tdp_ram.sv
// Bench for param_tdp_ram: a read-first and a write-first instance share stimulus
// and are checked against an array model; a third instance covers INIT_ON_RST=0.
module tb_param_tdp_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_en, a_we, b_en, b_we;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_din, b_din;

    logic       m_busy, m_a_valid, m_b_valid, m_col;
    logic [7:0] m_a_dout, m_b_dout;
    logic       w_busy, w_a_valid, w_b_valid, w_col;
    logic [7:0] w_a_dout, w_b_dout;
    logic       n_busy, n_a_valid, n_b_valid, n_col;
    logic [7:0] n_a_dout, n_b_dout;

    always #5 clk = ~clk;

    param_tdp_ram #(.DATA_W(8), .ADDR_W(3), .WRITE_MODE(0), .INIT_ON_RST(1), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .busy(m_busy),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(m_a_dout), .a_valid(m_a_valid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(m_b_dout), .b_valid(m_b_valid),
        .collision(m_col));

    param_tdp_ram #(.DATA_W(8), .ADDR_W(3), .WRITE_MODE(1), .INIT_ON_RST(1), .INIT_VAL(8'h00)) dut_wf (
        .clk(clk), .rst(rst), .busy(w_busy),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(w_a_dout), .a_valid(w_a_valid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(w_b_dout), .b_valid(w_b_valid),
        .collision(w_col));

    param_tdp_ram #(.DATA_W(8), .ADDR_W(3), .WRITE_MODE(0), .INIT_ON_RST(0), .INIT_VAL(8'h00)) dut_ni (
        .clk(clk), .rst(rst), .busy(n_busy),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(n_a_dout), .a_valid(n_a_valid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(n_b_dout), .b_valid(n_b_valid),
        .collision(n_col));

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: plain array plus remaining-sweep counter.
    logic [7:0] ref_mem [8];
    int         ref_busy_left = 8;
    logic [7:0] ref_a_dout = '0, ref_b_dout = '0, ref_a_dout_wf = '0, ref_b_dout_wf = '0;
    logic       ref_a_valid = 1'b0, ref_b_valid = 1'b0, ref_col = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_step();
        logic [7:0] old_mem [8];
        if (rst) begin
            ref_a_dout = '0; ref_b_dout = '0; ref_a_dout_wf = '0; ref_b_dout_wf = '0;
            ref_a_valid = 1'b0; ref_b_valid = 1'b0; ref_col = 1'b0;
            ref_busy_left = 8;
        end else if (ref_busy_left > 0) begin
            ref_mem[8 - ref_busy_left] = 8'h00;
            ref_busy_left--;
            ref_a_valid = 1'b0; ref_b_valid = 1'b0; ref_col = 1'b0;
        end else begin
            old_mem = ref_mem;
            ref_a_valid = a_en;
            ref_b_valid = b_en;
            if (a_en) begin
                ref_a_dout    = old_mem[a_addr];
                ref_a_dout_wf = a_we ? a_din : old_mem[a_addr];
            end
            if (b_en) begin
                ref_b_dout    = old_mem[b_addr];
                ref_b_dout_wf = b_we ? b_din : old_mem[b_addr];
            end
            ref_col = a_en && b_en && a_we && b_we && (a_addr == b_addr);
            if (b_en && b_we) ref_mem[b_addr] = b_din;
            if (a_en && a_we) ref_mem[a_addr] = a_din;
        end
    endtask

    task automatic tick(input logic r, input logic ae, input logic awe, input logic [2:0] aa,
                        input logic [7:0] ad, input logic be, input logic bwe,
                        input logic [2:0] ba, input logic [7:0] bd);
        rst = r; a_en = ae; a_we = awe; a_addr = aa; a_din = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_din = bd;
        @(posedge clk);
        model_step();
        #1;
        $display("txn rst=%0b A(%0b%0b @%0d %h) B(%0b%0b @%0d %h) -> busy=%0b a=%0b/%h b=%0b/%h col=%0b",
                 r, ae, awe, aa, ad, be, bwe, ba, bd, m_busy, m_a_valid, m_a_dout, m_b_valid, m_b_dout, m_col);
        check("busy",        m_busy,    (ref_busy_left > 0));
        check("a_valid",     m_a_valid, ref_a_valid);
        check("b_valid",     m_b_valid, ref_b_valid);
        check("a_dout",      m_a_dout,  ref_a_dout);
        check("b_dout",      m_b_dout,  ref_b_dout);
        check("collision",   m_col,     ref_col);
        check("wf_busy",     w_busy,    (ref_busy_left > 0));
        check("wf_a_valid",  w_a_valid, ref_a_valid);
        check("wf_a_dout",   w_a_dout,  ref_a_dout_wf);
        check("wf_b_dout",   w_b_dout,  ref_b_dout_wf);
        check("wf_collision", w_col,    ref_col);
    endtask

    typedef struct {
        logic       r, ae, awe, be, bwe;
        logic [2:0] aa, ba;
        logic [7:0] ad, bd;
        logic       e_busy, e_av, e_bv, e_col;
        logic [7:0] e_ad, e_bd, e_ad_wf, e_bd_wf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic ae, input logic awe, input logic [2:0] aa,
                                input logic [7:0] ad, input logic be, input logic bwe,
                                input logic [2:0] ba, input logic [7:0] bd,
                                input logic e_busy, input logic e_av, input logic [7:0] e_ad,
                                input logic e_bv, input logic [7:0] e_bd, input logic e_col,
                                input logic [7:0] e_ad_wf, input logic [7:0] e_bd_wf);
        vec_t v;
        v.r = r; v.ae = ae; v.awe = awe; v.aa = aa; v.ad = ad;
        v.be = be; v.bwe = bwe; v.ba = ba; v.bd = bd;
        v.e_busy = e_busy; v.e_av = e_av; v.e_ad = e_ad; v.e_bv = e_bv; v.e_bd = e_bd;
        v.e_col = e_col; v.e_ad_wf = e_ad_wf; v.e_bd_wf = e_bd_wf;
        vecs.push_back(v);
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'hxx;

        // Reset for two cycles, then the 8-cycle sweep.
        add(1,0,0,0,0, 0,0,0,0,  1, 0,8'h00, 0,8'h00, 0, 8'h00,8'h00);
        add(1,0,0,0,0, 0,0,0,0,  1, 0,8'h00, 0,8'h00, 0, 8'h00,8'h00);
        for (int i = 0; i < 8; i++)
            add(0,0,0,0,0, 0,0,0,0,  (i < 7), 0,8'h00, 0,8'h00, 0, 8'h00,8'h00);
        for (int i = 0; i < 8; i++)
            add(0,1,0,3'(i),0, 0,0,0,0,  0, 1,8'h00, 0,8'h00, 0, 8'h00,8'h00);
        // Cross-port sequences.
        add(0,1,1,3,8'hDD, 0,0,0,0,     0, 1,8'h00, 0,8'h00, 0, 8'hDD,8'h00);
        add(0,0,0,0,0,     1,0,3,0,     0, 0,8'h00, 1,8'hDD, 0, 8'hDD,8'hDD);
        add(0,1,1,5,8'h11, 1,0,5,0,     0, 1,8'h00, 1,8'h00, 0, 8'h11,8'h00);
        add(0,0,0,0,0,     1,0,5,0,     0, 0,8'h00, 1,8'h11, 0, 8'h11,8'h11);
        // Same-port read-during-write.
        add(0,1,1,2,8'hAE, 0,0,0,0,     0, 1,8'h00, 0,8'h11, 0, 8'hAE,8'h11);
        add(0,1,1,2,8'h5C, 0,0,0,0,     0, 1,8'hAE, 0,8'h11, 0, 8'h5C,8'h11);
        add(0,1,0,2,0,     0,0,0,0,     0, 1,8'h5C, 0,8'h11, 0, 8'h5C,8'h11);
        // Write/write collision, port A wins.
        add(0,1,1,6,8'h01, 1,1,6,8'h02, 0, 1,8'h00, 1,8'h00, 1, 8'h01,8'h02);
        add(0,0,0,0,0,     0,0,0,0,     0, 0,8'h00, 0,8'h00, 0, 8'h01,8'h02);
        add(0,1,0,6,0,     0,0,0,0,     0, 1,8'h01, 0,8'h00, 0, 8'h01,8'h02);

        foreach (vecs[k]) begin
            tick(vecs[k].r, vecs[k].ae, vecs[k].awe, vecs[k].aa, vecs[k].ad,
                 vecs[k].be, vecs[k].bwe, vecs[k].ba, vecs[k].bd);
            check("vec_busy",   m_busy,    vecs[k].e_busy);
            check("vec_a_valid", m_a_valid, vecs[k].e_av);
            check("vec_a_dout", m_a_dout,  vecs[k].e_ad);
            check("vec_b_valid", m_b_valid, vecs[k].e_bv);
            check("vec_b_dout", m_b_dout,  vecs[k].e_bd);
            check("vec_col",    m_col,     vecs[k].e_col);
            check("vec_wf_a_dout", w_a_dout, vecs[k].e_ad_wf);
            check("vec_wf_b_dout", w_b_dout, vecs[k].e_bd_wf);
        end

        // Reset mid-sweep restarts the full sweep; requests while busy are dropped.
        tick(1,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 4; i++) tick(0,0,0,0,0, 0,0,0,0);
        check("midsweep_busy", m_busy, 1'b1);
        tick(1,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 8; i++) begin
            tick(0,1,1,7,8'hFF, 1,1,7,8'hAA);
            check("busy_window", m_busy, (i < 7));
            check("busy_no_a_valid", m_a_valid, 1'b0);
            check("busy_no_b_valid", m_b_valid, 1'b0);
        end
        tick(0,1,0,7,0, 1,0,7,0);
        check("mem7_a_after_busy", m_a_dout, 8'h00);
        check("mem7_b_after_busy", m_b_dout, 8'h00);
        check("mem7_valid", m_a_valid, 1'b1);

        // INIT_ON_RST=0 instance keeps contents through reset.
        tick(0,1,1,1,8'h7E, 0,0,0,0);
        check("ni_wr_valid", n_a_valid, 1'b1);
        tick(1,0,0,0,0, 0,0,0,0);
        check("ni_busy_rst", n_busy, 1'b0);
        check("ni_a_dout_rst", n_a_dout, 8'h00);
        check("ni_a_valid_rst", n_a_valid, 1'b0);
        tick(0,1,0,1,0, 0,0,0,0);
        check("ni_busy_after", n_busy, 1'b0);
        check("ni_rd_valid", n_a_valid, 1'b1);
        check("ni_rd_data", n_a_dout, 8'h7E);
        for (int i = 0; i < 8; i++) tick(0,0,0,0,0, 0,0,0,0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 79) == 0),
                 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
